// File: rtl/rst_seq_gen.sv
// rst_seq_gen: staggered per-channel reset release with divided clock-enable ticks.
// Ports: clk_i/rst_ni clock and async active-low reset; test_mode_i scan bypass;
//        div_i per-channel divide ratios; soft_rst_req_i/soft_rst_ack_o 4-phase soft reset;
//        rst_no per-channel active-low resets; clk_en_o per-channel ticks; busy_o sequence active.
// Optional: define RST_SEQ_GEN_SOFT_RST_EN to enable the soft-reset handshake.
`timescale 1ns/1ps
module rst_seq_gen #(
    parameter int NumChan      = 4,
    parameter int RstClkCycles = 5,
    parameter int DivWidth     = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        test_mode_i,
    input  logic [NumChan*DivWidth-1:0] div_i,
    input  logic                        soft_rst_req_i,
    output logic                        soft_rst_ack_o,
    output logic [NumChan-1:0]          rst_no,
    output logic [NumChan-1:0]          clk_en_o,
    output logic                        busy_o
);
    localparam int CntW = $clog2(RstClkCycles + 1);
    localparam int IdxW = (NumChan > 1) ? $clog2(NumChan) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(RstClkCycles - 1);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumChan - 1);

    typedef enum logic [1:0] {HOLD, RELEASE, RUN} state_e;

    state_e                             state_q, state_d;
    logic [CntW-1:0]                    cnt_q, cnt_d;
    logic [IdxW-1:0]                    idx_q, idx_d;
    logic [NumChan-1:0]                 rst_q, rst_d, en_q, en_d;
    logic                               busy_q, busy_d, ack_q, ack_d, pend_q, pend_d;
    logic [NumChan-1:0][DivWidth-1:0]   dcnt_q, dcnt_d;
    logic                               soft_go;

`ifdef RST_SEQ_GEN_SOFT_RST_EN
    assign soft_go        = state_q == RUN && soft_rst_req_i && !ack_q;
    assign soft_rst_ack_o = ack_q;
`else
    assign soft_go        = 1'b0;
    assign soft_rst_ack_o = 1'b0;
`endif

    // Ratios 0 and 1 both mean "tick every released cycle".
    function automatic logic [DivWidth-1:0] thr_of(input logic [DivWidth-1:0] d);
        return (d > DivWidth'(1)) ? d - 1'b1 : '0;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_d   = rst_q;
        busy_d  = busy_q;
        pend_d  = pend_q;
        ack_d   = ack_q && soft_rst_req_i;
        en_d    = '0;
        dcnt_d  = '0;
        if (soft_go) begin
            state_d = HOLD;
            cnt_d   = '0;
            idx_d   = '0;
            rst_d   = '0;
            busy_d  = 1'b1;
            pend_d  = 1'b1;
        end else if (state_q != RUN) begin
            // HOLD and RELEASE share the interval count; idx_q is 0 in HOLD.
            cnt_d = (cnt_q == LastCnt) ? '0 : cnt_q + 1'b1;
            if (cnt_q == LastCnt) begin
                rst_d[idx_q] = 1'b1;
                idx_d        = idx_q + 1'b1;
                state_d      = (idx_q == LastIdx) ? RUN : RELEASE;
                if (idx_q == LastIdx) begin
                    idx_d  = '0;
                    busy_d = 1'b0;
                    ack_d  = ack_d || pend_q;
                    pend_d = 1'b0;
                end
            end
        end
        // A channel only counts while released both before and after this edge,
        // so the release edge and the soft-reset edge never produce a tick.
        for (int k = 0; k < NumChan; k++) begin
            en_d[k]   = rst_d[k] && rst_q[k] && dcnt_q[k] >= thr_of(div_i[k*DivWidth +: DivWidth]);
            dcnt_d[k] = (rst_d[k] && rst_q[k] && !en_d[k]) ? dcnt_q[k] + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '0;
            en_q    <= '0;
            busy_q  <= 1'b1;
            ack_q   <= 1'b0;
            pend_q  <= 1'b0;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            pend_q  <= pend_d;
            dcnt_q  <= dcnt_d;
        end
    end

    assign rst_no   = test_mode_i ? {NumChan{rst_ni}} : rst_q;
    assign clk_en_o = test_mode_i ? '1 : en_q;
    assign busy_o   = busy_q;
endmodule

// File: tb/tb_rst_seq_gen.sv
// tb_rst_seq_gen: vector tables, directed corner sequences and random stimulus against a timeline model.
`timescale 1ns/1ps
module tb_rst_seq_gen;
    localparam int N  = 4;
    localparam int R  = 5;
    localparam int DW = 4;
`ifdef RST_SEQ_GEN_SOFT_RST_EN
    localparam bit SOFT = 1'b1;
`else
    localparam bit SOFT = 1'b0;
`endif

    logic            clk_i = 1'b0;
    logic            rst_ni, test_mode_i, soft_rst_req_i, soft_rst_ack_o, busy_o;
    logic [N*DW-1:0] div_i;
    logic [N-1:0]    rst_no, clk_en_o;

    int checks = 0;
    int errors = 0;

    int           t, e;
    int           last [N];
    logic         ack_m, pend_m;
    logic [N-1:0] en_m;

    typedef struct {int cyc; logic [N-1:0] rst; logic busy;} sched_t;
    typedef struct {int ch; int ticks;} tickv_t;
    typedef struct {logic tm; logic rn; logic [N-1:0] rst; logic [N-1:0] en;} tmv_t;

    sched_t sched [8];
    tickv_t tickv [4];
    tmv_t   tmv   [4];
    int     seen  [N];

    rst_seq_gen #(.NumChan(N), .RstClkCycles(R), .DivWidth(DW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .test_mode_i(test_mode_i), .div_i(div_i),
        .soft_rst_req_i(soft_rst_req_i), .soft_rst_ack_o(soft_rst_ack_o),
        .rst_no(rst_no), .clk_en_o(clk_en_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Channel k is out of reset once (k+1)*R edges have elapsed in the current sequence.
    function automatic logic [N-1:0] rel_of(input int tt);
        logic [N-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) r[k] = tt >= (k + 1) * R;
        return r;
    endfunction

    task automatic model_reset();
        t = 0;
        ack_m = 1'b0;
        pend_m = 1'b0;
        en_m = '0;
    endtask

    task automatic model_edge();
        logic [N-1:0] ro, rn;
        logic go, nack;
        int told, d;
        e++;
        if (!rst_ni) begin
            model_reset();
            return;
        end
        told = t;
        ro = rel_of(t);
        go = SOFT && told >= N * R && soft_rst_req_i && !ack_m;
        nack = ack_m && soft_rst_req_i;
        t = go ? 0 : t + 1;
        if (go) pend_m = 1'b1;
        rn = rel_of(t);
        if (!go && pend_m && told < N * R && t >= N * R) begin
            nack = 1'b1;
            pend_m = 1'b0;
        end
        ack_m = nack;
        // A tick fires once at least div edges have passed since the last tick or release.
        for (int k = 0; k < N; k++) begin
            d = int'(div_i[k*DW +: DW]);
            if (d == 0) d = 1;
            en_m[k] = ro[k] && rn[k] && (e - last[k] >= d);
            if (en_m[k] || (rn[k] && !ro[k])) last[k] = e;
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".rst_no"}, 32'(rst_no), 32'(test_mode_i ? {N{rst_ni}} : rel_of(t)));
        chk({tag, ".clk_en"}, 32'(clk_en_o), 32'(test_mode_i ? {N{1'b1}} : en_m));
        chk({tag, ".busy"}, 32'(busy_o), 32'(t < N * R));
        chk({tag, ".ack"}, 32'(soft_rst_ack_o), 32'(ack_m));
    endtask

    task automatic tick(input string tag);
        @(posedge clk_i);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    initial begin
        sched[0] = '{4,  4'b0000, 1'b1};
        sched[1] = '{5,  4'b0001, 1'b1};
        sched[2] = '{9,  4'b0001, 1'b1};
        sched[3] = '{10, 4'b0011, 1'b1};
        sched[4] = '{15, 4'b0111, 1'b1};
        sched[5] = '{19, 4'b0111, 1'b1};
        sched[6] = '{20, 4'b1111, 1'b0};
        sched[7] = '{22, 4'b1111, 1'b0};
        tickv[0] = '{0, 10};
        tickv[1] = '{1, 30};
        tickv[2] = '{2, 30};
        tickv[3] = '{3, 2};
        tmv[0]   = '{1'b1, 1'b1, 4'hF, 4'hF};
        tmv[1]   = '{1'b1, 1'b0, 4'h0, 4'hF};
        tmv[2]   = '{1'b1, 1'b1, 4'hF, 4'hF};
        tmv[3]   = '{1'b0, 1'b1, 4'h0, 4'h0};

        rst_ni = 1'b0;
        test_mode_i = 1'b0;
        soft_rst_req_i = 1'b0;
        div_i = {4'd15, 4'd1, 4'd0, 4'd3};
        e = 0;
        for (int k = 0; k < N; k++) last[k] = 0;
        model_reset();
        repeat (2) tick("reset");
        chk("reset_rst_no", 32'(rst_no), 32'(0));
        chk("reset_clk_en", 32'(clk_en_o), 32'(0));
        chk("reset_busy", 32'(busy_o), 32'(1));
        chk("reset_ack", 32'(soft_rst_ack_o), 32'(0));

        rst_ni = 1'b1;
        for (int n = 1; n <= 52; n++) begin
            tick("startup");
            for (int i = 0; i < 8; i++)
                if (sched[i].cyc == n) begin
                    chk($sformatf("sched_rst_e%0d", n), 32'(rst_no), 32'(sched[i].rst));
                    chk($sformatf("sched_busy_e%0d", n), 32'(busy_o), 32'(sched[i].busy));
                end
            if (n >= 23)
                for (int k = 0; k < N; k++) seen[k] += int'(clk_en_o[k]);
            else
                for (int k = 0; k < N; k++) seen[k] = 0;
        end
        for (int i = 0; i < 4; i++)
            chk($sformatf("tick_count_ch%0d", tickv[i].ch), 32'(seen[tickv[i].ch]), 32'(tickv[i].ticks));

`ifdef RST_SEQ_GEN_SOFT_RST_EN
        soft_rst_req_i = 1'b1;
        tick("soft_go");
        chk("soft_all_low", 32'(rst_no), 32'(0));
        chk("soft_busy", 32'(busy_o), 32'(1));
        for (int i = 1; i <= 20; i++) begin
            tick("soft_seq");
            if (i == 19) chk("soft_ack_early", 32'(soft_rst_ack_o), 32'(0));
            if (i == 19) chk("soft_rst_e19", 32'(rst_no), 32'(4'b0111));
        end
        chk("soft_ack_rise", 32'(soft_rst_ack_o), 32'(1));
        chk("soft_rst_done", 32'(rst_no), 32'(4'hF));
        chk("soft_busy_done", 32'(busy_o), 32'(0));
        for (int i = 0; i < 8; i++) begin
            tick("soft_hold");
            chk("soft_no_retrigger", 32'(rst_no), 32'(4'hF));
        end
        soft_rst_req_i = 1'b0;
        tick("soft_drop");
        chk("soft_ack_fall", 32'(soft_rst_ack_o), 32'(0));
`else
        soft_rst_req_i = 1'b1;
        repeat (25) tick("soft_ignored");
        chk("soft_ignored_rst", 32'(rst_no), 32'(4'hF));
        chk("soft_ignored_ack", 32'(soft_rst_ack_o), 32'(0));
        chk("soft_ignored_busy", 32'(busy_o), 32'(0));
        soft_rst_req_i = 1'b0;
`endif

        for (int i = 0; i < 4; i++) begin
            test_mode_i = tmv[i].tm;
            rst_ni = tmv[i].rn;
            if (!rst_ni) model_reset();
            #1;
            chk($sformatf("tm_vec%0d_rst", i), 32'(rst_no), 32'(tmv[i].rst));
            chk($sformatf("tm_vec%0d_en", i), 32'(clk_en_o), 32'(tmv[i].en));
        end

        repeat (12) tick("pre_abort");
        chk("abort_pre_rst", 32'(rst_no), 32'(4'b0011));
        rst_ni = 1'b0;
        model_reset();
        #1;
        chk("abort_rst", 32'(rst_no), 32'(0));
        chk("abort_busy", 32'(busy_o), 32'(1));
        chk("abort_en", 32'(clk_en_o), 32'(0));
        tick("abort_low");
        rst_ni = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            tick("retime");
            if (n == 4) chk("retime_e4", 32'(rst_no), 32'(0));
            if (n == 5) chk("retime_e5", 32'(rst_no), 32'(4'b0001));
        end

        for (int i = 0; i < 3000; i++) begin
            tick("rnd");
            if (!rst_ni) begin
                if ($urandom_range(0, 1) == 0) rst_ni = 1'b1;
            end else if ($urandom_range(0, 199) == 0) begin
                rst_ni = 1'b0;
                model_reset();
                #1;
                compare_all("rnd_arst");
            end
            if ($urandom_range(0, 15) == 0) div_i = 16'($urandom);
            if ($urandom_range(0, 9) == 0) soft_rst_req_i = ~soft_rst_req_i;
            test_mode_i = test_mode_i ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 63) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rst_seq_gen.md
RST_SEQ_GEN -- requirements
Module: rst_seq_gen

Interface
- REQ-001: The block SHALL have parameter NumChan, default 4, giving the number of sequenced reset/clock-enable channels (1..16).
- REQ-002: The block SHALL have parameter RstClkCycles, default 5, giving the hold/stagger interval in cycles (1..255).
- REQ-003: The block SHALL have parameter DivWidth, default 4, giving the width of each channel divide ratio.
- REQ-004: The block SHALL have port clk_i, input, width 1: the single clock for all logic.
- REQ-005: The block SHALL have port rst_ni, input, width 1: reset, asynchronous, active-low.
- REQ-006: The block SHALL have port test_mode_i, input, width 1: scan bypass.
- REQ-007: The block SHALL have port div_i, input, width NumChan*DivWidth: per-channel divide ratio, with channel k at bits [k*DivWidth +: DivWidth].
- REQ-008: The block SHALL have port soft_rst_req_i, input, width 1: soft-reset request (4-phase).
- REQ-009: The block SHALL have port soft_rst_ack_o, output, width 1: soft-reset acknowledge (4-phase).
- REQ-010: The block SHALL have port rst_no, output, width NumChan: per-channel active-low resets.
- REQ-011: The block SHALL have port clk_en_o, output, width NumChan: per-channel divided clock-enable ticks.
- REQ-012: The block SHALL have port busy_o, output, width 1: high while any channel is held in reset.

Function
- REQ-013: The block SHALL implement an FSM with states HOLD, RELEASE and RUN, plus an interval counter of width clog2(RstClkCycles+1) and a channel index counter.
- REQ-014: In HOLD, all rst_no SHALL be low and the interval counter SHALL count 0..RstClkCycles-1; on the last count the FSM SHALL enter RELEASE and set rst_no[0] on the same edge.
- REQ-015: In RELEASE, rst_no[k+1] SHALL be set exactly RstClkCycles cycles after rst_no[k]; once rst_no[NumChan-1] is set, the FSM SHALL enter RUN on that edge.
- REQ-016: Channel k SHALL be released on rising edge (k+1)*RstClkCycles, counted from the first edge with rst_ni high.
- REQ-017: With NumChan=1, the FSM SHALL go HOLD -> RUN directly.
- REQ-018: busy_o SHALL be high in HOLD and RELEASE and low in RUN, falling on the same edge as the last release.
- REQ-019: Each channel SHALL have a divider counter held at 0 while its rst_no is low.
- REQ-020: When released, a channel divider counter SHALL increment each cycle; when it reaches div-1, clk_en_o[k] SHALL pulse high for one cycle and the counter SHALL wrap to 0.
- REQ-021: A channel with div_i value 0 or 1 SHALL have clk_en_o[k] high every cycle while released.
- REQ-022: If div_i changes so that counter >= new div-1, the channel SHALL tick on the next cycle and wrap; div_i SHALL NOT otherwise cause glitch pulses.
- REQ-023: Soft reset: in RUN with soft_rst_req_i=1 and soft_rst_ack_o=0, all rst_no SHALL go low on the next edge and the FSM SHALL enter HOLD, running the full sequence again.
- REQ-024: soft_rst_ack_o SHALL rise on the edge the FSM re-enters RUN after a soft reset, stay high until soft_rst_req_i is sampled low, then fall on the next edge.
- REQ-025: A new soft reset SHALL NOT start while soft_rst_ack_o=1.
- REQ-026: soft_rst_req_i SHALL be ignored in HOLD and RELEASE; if it is still high at RUN entry, the ack rule applies and no re-trigger occurs.
- REQ-027: When test_mode_i=1, rst_no SHALL equal {NumChan{rst_ni}} combinationally, clk_en_o SHALL be all ones, and the FSM SHALL keep running internally, unobserved.
- REQ-028: All non-test-mode outputs SHALL be registered.

Reset
- REQ-029: When rst_ni is low (asynchronous), the FSM SHALL be in HOLD with counters at 0, rst_no='0, clk_en_o='0, soft_rst_ack_o=0 and busy_o=1.
- REQ-030: rst_ni assertion mid-sequence or mid-soft-reset SHALL abort immediately; release SHALL restart from HOLD with full timing.

Configuration
- REQ-031: With macro RST_SEQ_GEN_SOFT_RST_EN defined, REQ-023 to REQ-026 SHALL apply.
- REQ-032: Without RST_SEQ_GEN_SOFT_RST_EN, soft_rst_req_i SHALL be ignored, soft_rst_ack_o SHALL be tied 0, and the ports SHALL remain present.

Verification (NumChan=4, RstClkCycles=5, DivWidth=4)
- REQ-033: rst_ni released at edge 0 -> rst_no bits 0..3 rise at edges 5/10/15/20, and busy_o falls at edge 20.
- REQ-034: div_i ch0=3, ch1=0, ch2=1, ch3=15 after RUN -> ch0 ticks every 3rd cycle, ch1 and ch2 every cycle, ch3 every 15th cycle; no ticks before each channel's release.
- REQ-035: In RUN, soft_rst_req_i=1 held -> all rst_no low next edge, staggered re-release 5/10/15/20 cycles later, ack rises with the last release; drop req -> ack falls next edge; req held high after ack -> no second sequence.
- REQ-036: rst_ni pulsed low at cycle 12 (channels 0,1 released) -> all outputs return to reset values immediately; release re-times from 5.
- REQ-037: test_mode_i=1 -> rst_no tracks rst_ni with zero latency and clk_en_o=4'hF; with RST_SEQ_GEN_SOFT_RST_EN undefined, req=1 -> no effect and ack stays 0.
